// File: rtl/rca_arbiter.sv
// rca_arbiter: two-requester arbiter in front of a shared external ripple-carry
// adder, with multi-word bursts chained through a carry register.
//
// Ports
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_reqX_valid / o_reqX_ready     requester X handshake (ready is combinational)
//   i_reqX_a, i_reqX_b              requester X operands (N bits)
//   i_reqX_cin                      carry-in, used on the first word of a burst
//   i_reqX_last                     final word of a burst
//   o_add_a, o_add_b, o_add_cin     operands driven to the adder (combinational)
//   i_add_sum, i_add_cout           adder result
//   o_rsp_valid/id/sum/cout/last    registered result, one cycle after transfer
//   o_err                           one-cycle pulse when a stalled burst is aborted
//
// Build option: define RCA_ARB_TIMEOUT_EN to abort a lock after 16 consecutive
// cycles in which the locked requester presents no word. Without it the lock is
// held indefinitely and o_err stays 0.
module rca_arbiter #(
    parameter int unsigned N = 19
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_req0_valid,
    input  logic         i_req1_valid,
    output logic         o_req0_ready,
    output logic         o_req1_ready,
    input  logic [N-1:0] i_req0_a,
    input  logic [N-1:0] i_req0_b,
    input  logic [N-1:0] i_req1_a,
    input  logic [N-1:0] i_req1_b,
    input  logic         i_req0_cin,
    input  logic         i_req1_cin,
    input  logic         i_req0_last,
    input  logic         i_req1_last,
    output logic [N-1:0] o_add_a,
    output logic [N-1:0] o_add_b,
    output logic         o_add_cin,
    input  logic [N-1:0] i_add_sum,
    input  logic         i_add_cout,
    output logic         o_rsp_valid,
    output logic         o_rsp_id,
    output logic [N-1:0] o_rsp_sum,
    output logic         o_rsp_cout,
    output logic         o_rsp_last,
    output logic         o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_ptr;
    logic         w_ptr_nxt;
    logic         r_creg;
    logic         w_sel_en;
    logic         w_sel;
    logic         w_sel_valid;
    logic         w_sel_last;
    logic         w_xfer;
    logic         w_abort;

    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_sum;
    logic         r_rsp_cout;
    logic         r_rsp_last;
    logic         r_err;

    // Grant selection: in IDLE the valid requester (PTR breaks ties), in LOCKx the owner.
    always_comb begin
        w_sel_en = 1'b0;
        w_sel    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req0_valid && i_req1_valid) begin
                    w_sel_en = 1'b1;
                    w_sel    = r_ptr;
                end else if (i_req0_valid) begin
                    w_sel_en = 1'b1;
                    w_sel    = 1'b0;
                end else if (i_req1_valid) begin
                    w_sel_en = 1'b1;
                    w_sel    = 1'b1;
                end
            end
            LOCK0: begin
                w_sel_en = 1'b1;
                w_sel    = 1'b0;
            end
            LOCK1: begin
                w_sel_en = 1'b1;
                w_sel    = 1'b1;
            end
            default: begin
                w_sel_en = 1'b0;
                w_sel    = 1'b0;
            end
        endcase
    end

    assign w_sel_valid  = w_sel ? i_req1_valid : i_req0_valid;
    assign w_sel_last   = w_sel ? i_req1_last  : i_req0_last;
    assign w_xfer       = w_sel_en && w_sel_valid;
    assign o_req0_ready = w_sel_en && !w_sel;
    assign o_req1_ready = w_sel_en && w_sel;

    // Adder operand mux; the burst's first word takes the requester's carry-in,
    // later words chain the carry register.
    always_comb begin
        o_add_a   = '0;
        o_add_b   = '0;
        o_add_cin = 1'b0;
        if (w_sel_en) begin
            o_add_a   = w_sel ? i_req1_a : i_req0_a;
            o_add_b   = w_sel ? i_req1_b : i_req0_b;
            o_add_cin = (r_state == IDLE) ? (w_sel ? i_req1_cin : i_req0_cin) : r_creg;
        end
    end

`ifdef RCA_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = 4;
    logic [TO_W-1:0] r_to_cnt;

    // Abort on the 16th consecutive locked cycle without a word.
    assign w_abort = (r_state != IDLE) && !w_sel_valid && (r_to_cnt == {TO_W{1'b1}});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_xfer || w_abort) begin
            r_to_cnt <= '0;
        end else if ((r_state != IDLE) && !w_sel_valid) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Next state and priority pointer.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (w_xfer) begin
            if (w_sel_last) begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = !w_sel;
            end else begin
                w_state_nxt = w_sel ? LOCK1 : LOCK0;
            end
        end else if (w_abort) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = !w_sel;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer, carry chain and registered response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= 1'b0;
            r_creg      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_rsp_valid <= w_xfer;
            r_err       <= w_abort;
            if (w_xfer) begin
                r_creg     <= i_add_cout;
                r_rsp_id   <= w_sel;
                r_rsp_sum  <= i_add_sum;
                r_rsp_cout <= i_add_cout;
                r_rsp_last <= w_sel_last;
            end else if (w_abort) begin
                r_creg <= 1'b0;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_sum   = r_rsp_sum;
    assign o_rsp_cout  = r_rsp_cout;
    assign o_rsp_last  = r_rsp_last;
    assign o_err       = r_err;

endmodule

// File: doc/rca_arbiter.md
RCA_ARBITER -- requirements
Module: rca_arbiter

Interface
REQ-001 Parameter N, default 19, operand/sum width in bits.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset; asynchronous, active-low.
REQ-004 REQ0_VALID, REQ1_VALID  input  1 each  requester x presents a word.
REQ-005 REQ0_READY, REQ1_READY  output  1 each  word accepted this cycle when VALID&READY.
REQ-006 REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  N each  operands.
REQ-007 REQ0_CIN, REQ1_CIN  input  1 each  carry-in, used on first word of a burst only.
REQ-008 REQ0_LAST, REQ1_LAST  input  1 each  final word of a multi-word burst.
REQ-009 ADD_A, ADD_B  output  N  operands driven to the shared ripple-carry adder.
REQ-010 ADD_CIN  output  1  carry-in driven to the adder.
REQ-011 ADD_SUM  input  N, ADD_COUT  input  1  adder result (combinational path from ADD_A/ADD_B/ADD_CIN).
REQ-012 RSP_VALID  output  1  one-cycle pulse, registered result available.
REQ-013 RSP_ID  output  1  requester of the result (0/1).
REQ-014 RSP_SUM  output  N, RSP_COUT  output  1, RSP_LAST  output  1  registered result fields.
REQ-015 ERR  output  1  one-cycle pulse on burst abort (see Configuration).

Function
REQ-016 States SHALL be IDLE, LOCK0, LOCK1.
REQ-017 In IDLE, the winner SHALL be the valid requester; if both are valid, the one named by priority pointer PTR.
REQ-018 READY SHALL be combinational: asserted for the IDLE winner, or for the locked requester in LOCKx; never for both.
REQ-019 On a transfer with LAST=0 from IDLE, state SHALL go to LOCKx; in LOCKx the other requester SHALL receive READY=0.
REQ-020 On a transfer with LAST=1, state SHALL go to IDLE and PTR SHALL be set to the other requester.
REQ-021 In IDLE a single-word transfer (LAST=1) SHALL leave state IDLE.
REQ-022 ADD_A/ADD_B SHALL mux the selected requester's operands; zeros when no requester is selected.
REQ-023 ADD_CIN SHALL be REQx_CIN in IDLE and the carry register CREG in LOCKx.
REQ-024 CREG SHALL load ADD_COUT on every transfer.
REQ-025 Latency SHALL be one cycle: the cycle after a transfer, RSP_VALID=1 with RSP_SUM=ADD_SUM, RSP_COUT=ADD_COUT, RSP_ID and RSP_LAST as sampled at transfer.
REQ-026 One transfer per cycle maximum; back-to-back transfers SHALL produce back-to-back RSP_VALID pulses.
REQ-027 In LOCKx with VALID=0 the block SHALL hold state and CREG, with no response.
REQ-028 Sum SHALL be (A+B+CIN) mod 2^N with overflow carried in RSP_COUT; no saturation.

Reset
REQ-029 With RST_N=0: state=IDLE, PTR=0, CREG=0, RSP_VALID=0, RSP_ID=0, RSP_SUM=0, RSP_COUT=0, RSP_LAST=0, ERR=0, timeout counter=0.
REQ-030 Reset mid-burst SHALL drop the burst without a response; the first transfer after reset is treated as a first word.

Configuration
REQ-031 Macro RCA_ARB_TIMEOUT_EN defined: a 4-bit counter SHALL count consecutive LOCKx cycles with VALID=0; at 16 it SHALL abort to IDLE, set PTR to the other requester, pulse ERR, clear CREG and the counter. A transfer clears the counter.
REQ-032 Macro RCA_ARB_TIMEOUT_EN undefined: no counter; lock is held indefinitely; ERR tied to 0.

Verification
REQ-033 After reset, REQ0 A=5, B=7, CIN=1, LAST=1 -> next cycle RSP_VALID=1, RSP_ID=0, RSP_SUM=13, RSP_COUT=0.
REQ-034 REQ1 burst: word0 A=0x7FFFF, B=1, CIN=0, LAST=0; word1 A=0, B=0, LAST=1 -> responses SUM=0/COUT=1, then SUM=1/COUT=0/LAST=1.
REQ-035 Both VALID with LAST=1 right after reset -> REQ0 served first, then REQ1; PTR then returns to 0.
REQ-036 REQ0 in LOCK0 pauses 3 cycles while REQ1_VALID=1 -> REQ1_READY=0 throughout; REQ1 is granted the cycle after REQ0 LAST.
REQ-037 RST_N pulsed low in LOCK1 -> all outputs at reset values; next REQ1 word uses REQ1_CIN.
REQ-038 With RCA_ARB_TIMEOUT_EN, LOCK0 idle 16 cycles -> ERR pulse, IDLE, REQ1 granted; without the macro -> no ERR, lock held.
